// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 3;
    localparam int LEN_WIDTH      = 16;

    typedef enum logic [3:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        B0,
        B1,
        B2,
        WRITE,
        CHK,
        DONE,
        ERROR
    } state_e;

endpackage

// File: rtl/imem_loader.sv
// Assembles framed host bytes into instructions and writes them to imem,
// holding the pipeline in reset until the load finishes.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int INSTR_WIDTH = 19,
    parameter int ADDR_WIDTH  = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init,
    input  logic [7:0]             byteIn,
    input  logic                   byteValid,
    output logic                   byteReady,
    output logic                   imemWrite,
    output logic [ADDR_WIDTH-1:0]  imemAddress,
    output logic [INSTR_WIDTH-1:0] imemWriteData,
    output logic                   cpuHold,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    localparam int          HI_W      = INSTR_WIDTH - 16;
    localparam int unsigned MAX_WORDS = 1 << ADDR_WIDTH;

    state_e                   state_q, state_d;
    logic [LEN_WIDTH-1:0]     len_q, len_d;
    logic [ADDR_WIDTH:0]      idx_q, idx_d;
    logic [7:0]               chk_q, chk_d;
    logic [7:0]               b0_q, b0_d;
    logic [7:0]               b1_q, b1_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [INSTR_WIDTH-1:0]   wdata_q, wdata_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;

    logic                     xfer;
    logic [LEN_WIDTH-1:0]     len_in;
    logic [ADDR_WIDTH:0]      idx_inc;

    assign byteReady = state_q inside {LEN_LO, LEN_HI, B0, B1, B2, CHK};
    assign busy      = !(state_q inside {IDLE, DONE, ERROR});
    assign cpuHold   = busy;
    assign imemWrite = (state_q == WRITE);

    assign imemAddress   = addr_q;
    assign imemWriteData = wdata_q;
    assign done          = done_q;
    assign error         = error_q;

    assign xfer    = byteValid & byteReady;
    assign len_in  = {byteIn, len_q[7:0]};
    assign idx_inc = idx_q + (ADDR_WIDTH + 1)'(1);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        chk_d   = chk_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        error_d = error_q;

        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (init) begin
                    state_d = LEN_LO;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    chk_d   = 8'h00;
                    idx_d   = '0;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = byteIn;
                    chk_d      = chk_q ^ byteIn;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_d = len_in;
                    chk_d = chk_q ^ byteIn;
                    if (len_in == '0) begin
                        state_d = CHK;
                    end else if (32'(len_in) > MAX_WORDS) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end else begin
                        state_d = B0;
                    end
                end
            end
            B0: begin
                if (xfer) begin
                    b0_d    = byteIn;
                    chk_d   = chk_q ^ byteIn;
                    state_d = B1;
                end
            end
            B1: begin
                if (xfer) begin
                    b1_d    = byteIn;
                    chk_d   = chk_q ^ byteIn;
                    state_d = B2;
                end
            end
            B2: begin
                if (xfer) begin
                    // Upper bits beyond the instruction width must be zero.
                    if (byteIn[7:HI_W] != '0) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end else begin
                        chk_d   = chk_q ^ byteIn;
                        addr_d  = idx_q[ADDR_WIDTH-1:0];
                        wdata_d = {byteIn[HI_W-1:0], b1_q, b0_q};
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                idx_d = idx_inc;
                if (LEN_WIDTH'(idx_inc) == len_q) begin
                    state_d = CHK;
                end else begin
                    state_d = B0;
                end
            end
            CHK: begin
                if (xfer) begin
                    if ((chk_q ^ byteIn) == 8'h00) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            chk_q   <= '0;
            b0_q    <= '0;
            b1_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            chk_q   <= chk_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory that the fetch stage reads.
- Receives a framed byte stream from a host link over a valid/ready handshake and assembles 19-bit instructions.
- Writes the instructions into instruction memory at sequential 12-bit addresses.
- Holds the pipeline in reset (cpuHold) while loading and reports done or error on completion.

Parameters:
- INSTR_WIDTH, 19, instruction word width; 3 bytes per word.
- ADDR_WIDTH, 12, instruction memory address width; capacity is 2^ADDR_WIDTH words.

Ports:
- clk  input  1  single clock.
- rst  input  1  asynchronous, active-high reset.
- init  input  1  start a load; sampled only in IDLE, DONE or ERROR.
- byteIn  input  8  stream byte.
- byteValid  input  1  byteIn is valid.
- byteReady  output  1  loader accepts byteIn this cycle.
- imemWrite  output  1  one-cycle instruction memory write strobe.
- imemAddress  output  ADDR_WIDTH  write address.
- imemWriteData  output  INSTR_WIDTH  write data.
- cpuHold  output  1  high while a load is in progress; drives the pipeline reset.
- busy  output  1  FSM is not in IDLE, DONE or ERROR.
- done  output  1  sticky: last load succeeded.
- error  output  1  sticky: last load failed.

Behaviour:
- Reset (asynchronous, rst=1):
  - State goes to IDLE.
  - All outputs are 0.
  - Word index, length register and checksum are cleared.
- Frame format:
  - LEN_LO, LEN_HI: 16-bit word count N.
  - Then N×(B0, B1, B2).
  - Then CHK.
  - Instruction = {B2[2:0], B1, B0}.
- Handshake:
  - A byte transfers on a rising edge where byteValid & byteReady.
  - byteReady is 1 only in LEN_LO, LEN_HI, B0, B1, B2, CHK.
  - byteValid may stay high across WRITE; that byte is taken after WRITE.
- States and transitions:
  - IDLE/DONE/ERROR: init=1 → LEN_LO next cycle; clears done, error, checksum and word index; sets cpuHold=1 and busy=1. init is ignored in every other state.
  - LEN_LO → LEN_HI on transfer.
  - LEN_HI on transfer:
    - N=0 → CHK.
    - N > 2^ADDR_WIDTH → ERROR.
    - Otherwise → B0.
  - B0 → B1 → B2 on transfer.
  - B2 on transfer: B2[7:3] ≠ 0 → ERROR with no write; otherwise → WRITE.
  - WRITE (exactly one cycle):
    - imemWrite=1, imemAddress=wordIdx, imemWriteData=assembled word.
    - wordIdx increments.
    - Next state: CHK if wordIdx+1 == N, else B0.
  - CHK on transfer:
    - (checksum ^ byteIn) == 0 → DONE with done=1.
    - Otherwise → ERROR with error=1.
  - On entering DONE or ERROR: cpuHold=0 and busy=0 in the same cycle the state register updates.
- Checksum: running XOR of every accepted byte from LEN_LO through the last B2; CHK is compared, not accumulated.
- imemAddress and imemWriteData are registered; they hold their last value outside WRITE. imemWrite is 0 outside WRITE.
- Throughput: one word per 4 cycles minimum (3 transfers + WRITE).
- Total frame latency: 2 + 4N + 1 cycles after init with byteValid held high.
- Boundary cases:
  - N = 2^ADDR_WIDTH (4096): last write goes to address 4095 with no wrap; wordIdx is ADDR_WIDTH+1 bits wide.
  - Words already written before an ERROR stay in memory. cpuHold still drops, and software must check error.
  - rst mid-frame: immediate return to IDLE, imemWrite deasserts asynchronously, no further writes.
  - init and byteValid in the same cycle in IDLE: the byte is not accepted, because byteReady=0 in IDLE.

Decomposition:
- Shared package imem_loader_pkg holds:
  - the state encoding (IDLE, LEN_LO, LEN_HI, B0, B1, B2, WRITE, CHK, DONE, ERROR);
  - BYTES_PER_WORD=3;
  - LEN_WIDTH=16.
- No sub-module. The checksum is a single XOR register and stays inline.

Test Plan:
- N=1, bytes 0x34,0x12,0x05, CHK=0x01^0x00^0x34^0x12^0x05=0x22 → one imemWrite, address 0x000, data 0x51234; done=1; cpuHold falls 7 cycles after init.
- N=3, words 0x00001, 0x7FFFF, 0x40000, correct CHK, byteValid toggling every other cycle → writes at addresses 0,1,2 with exact data, each strobe exactly one cycle, done=1.
- N=0, CHK=0x00 → no imemWrite, done=1. N=0, CHK=0x5A → error=1.
- N=2, second word B2=0x08 → one write only (address 0), error=1, cpuHold=0, byteReady=0 afterward.
- N=0x1001 → error immediately after LEN_HI, no writes. N=0x1000 with valid data → last write at address 0xFFF, done=1.
- rst pulsed during B1 of word 5 → all outputs 0 the same cycle, no further writes; a subsequent init with a fresh frame loads correctly from address 0.
